// File: rtl/raster_walker.sv
// Emits every pixel of a clamped bounding box, one per cycle, with valid/ready backpressure.
// Optional feature macro: RASTER_SERPENTINE_EN (odd rows relative to y_min walk right-to-left).
module raster_walker #(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bbox_valid,
    output logic        bbox_ready,
    input  logic [15:0] bbox_x_min_int,
    input  logic [15:0] bbox_x_max_int,
    input  logic [15:0] bbox_y_min_int,
    input  logic [15:0] bbox_y_max_int,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [15:0] pix_x,
    output logic [15:0] pix_y,
    output logic        pix_last,
    output logic        done,
    output logic        empty,
    output logic [16:0] pix_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam logic [15:0] X_LIM = 16'(IMG_W - 1);
    localparam logic [15:0] Y_LIM = 16'(IMG_H - 1);
    localparam logic [16:0] W_EXT = 17'(IMG_W);
    localparam logic [16:0] H_EXT = 17'(IMG_H);

    state_t      state_reg, state_next;
    logic [15:0] x_reg, x_next;
    logic [15:0] y_reg, y_next;
    logic [15:0] x_min_reg, x_min_next;
    logic [15:0] x_max_reg, x_max_next;
    logic [15:0] y_max_reg, y_max_next;
    logic        rev_reg, rev_next;
    logic        last_reg, last_next;
    logic        empty_reg, empty_next;
    logic [16:0] cnt_reg, cnt_next;
    logic [16:0] pix_cnt_reg, pix_cnt_next;

    logic        box_empty;
    logic [15:0] x_max_clamp;
    logic [15:0] y_max_clamp;
    logic        row_end;

    // Emptiness uses the raw bounds; clamping only ever shrinks a non-empty box.
    assign box_empty = (bbox_x_min_int > bbox_x_max_int) ||
                       (bbox_y_min_int > bbox_y_max_int) ||
                       ({1'b0, bbox_x_min_int} >= W_EXT) ||
                       ({1'b0, bbox_y_min_int} >= H_EXT);
    assign x_max_clamp = (bbox_x_max_int > X_LIM) ? X_LIM : bbox_x_max_int;
    assign y_max_clamp = (bbox_y_max_int > Y_LIM) ? Y_LIM : bbox_y_max_int;

    assign row_end = rev_reg ? (x_reg == x_min_reg) : (x_reg == x_max_reg);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            x_reg       <= '0;
            y_reg       <= '0;
            x_min_reg   <= '0;
            x_max_reg   <= '0;
            y_max_reg   <= '0;
            rev_reg     <= 1'b0;
            last_reg    <= 1'b0;
            empty_reg   <= 1'b0;
            cnt_reg     <= '0;
            pix_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            x_reg       <= x_next;
            y_reg       <= y_next;
            x_min_reg   <= x_min_next;
            x_max_reg   <= x_max_next;
            y_max_reg   <= y_max_next;
            rev_reg     <= rev_next;
            last_reg    <= last_next;
            empty_reg   <= empty_next;
            cnt_reg     <= cnt_next;
            pix_cnt_reg <= pix_cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        x_min_next = x_min_reg;
        x_max_next = x_max_reg;
        y_max_next = y_max_reg;
        rev_next   = rev_reg;
        last_next  = last_reg;
        empty_next = 1'b0;
        cnt_next   = cnt_reg;

        case (state_reg)
            IDLE: begin
                if (bbox_valid) begin
                    x_min_next = bbox_x_min_int;
                    x_max_next = x_max_clamp;
                    y_max_next = y_max_clamp;
                    cnt_next   = '0;
                    rev_next   = 1'b0;
                    if (box_empty) begin
                        state_next = FIN;
                        empty_next = 1'b1;
                    end else begin
                        state_next = WALK;
                        x_next     = bbox_x_min_int;
                        y_next     = bbox_y_min_int;
                        last_next  = (bbox_x_min_int == x_max_clamp) &&
                                     (bbox_y_min_int == y_max_clamp);
                    end
                end
            end
            WALK: begin
                if (pix_ready) begin
                    cnt_next = cnt_reg + 17'd1;
                    if (last_reg) begin
                        state_next = FIN;
                        last_next  = 1'b0;
                    end else begin
                        if (row_end) begin
                            y_next = y_reg + 16'd1;
`ifdef RASTER_SERPENTINE_EN
                            rev_next = ~rev_reg;
                            x_next   = rev_reg ? x_min_reg : x_max_reg;
`else
                            x_next   = x_min_reg;
`endif
                        end else begin
                            x_next = rev_reg ? (x_reg - 16'd1) : (x_reg + 16'd1);
                        end
                        // Look ahead so pix_last is a plain register aligned with the next pixel.
                        last_next = (y_next == y_max_reg) &&
                                    (rev_next ? (x_next == x_min_reg) : (x_next == x_max_reg));
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        pix_cnt_next = (state_next == FIN) ? cnt_next : pix_cnt_reg;
    end

    assign bbox_ready = (state_reg == IDLE);
    assign pix_valid  = (state_reg == WALK);
    assign done       = (state_reg == FIN);
    assign empty      = empty_reg;
    assign pix_x      = x_reg;
    assign pix_y      = y_reg;
    assign pix_last   = last_reg;
    assign pix_cnt    = pix_cnt_reg;

endmodule

// File: tb/tb_raster_walker.sv
// Self-checking bench for raster_walker: directed boxes plus random boxes with random backpressure.
// Expected pixel streams come from a row-by-row reference model of the box walk.
module tb_raster_walker;

    localparam int IMG_W = 256;
    localparam int IMG_H = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bbox_valid = 1'b0;
    logic        bbox_ready;
    logic [15:0] bbox_x_min_int = '0;
    logic [15:0] bbox_x_max_int = '0;
    logic [15:0] bbox_y_min_int = '0;
    logic [15:0] bbox_y_max_int = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [15:0] pix_x;
    logic [15:0] pix_y;
    logic        pix_last;
    logic        done;
    logic        empty;
    logic [16:0] pix_cnt;

    int total = 0;
    int bad = 0;

    // Observed and expected streams: each entry is {x, y, last}.
    logic [32:0] obs_q[$];
    logic [32:0] exp_q[$];
    bit          exp_empty;
    int          r_done_cyc, r_last_hs, r_first_valid, r_hold_bad, r_done_pulses;
    bit          r_timeout, r_empty, r_ready_after, r_ready_at_done;
    logic [16:0] r_cnt;

    localparam logic [53:0] RESET_VALS = {1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0, 17'd0};

    raster_walker #(.IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
        .clk(clk), .rst(rst),
        .bbox_valid(bbox_valid), .bbox_ready(bbox_ready),
        .bbox_x_min_int(bbox_x_min_int), .bbox_x_max_int(bbox_x_max_int),
        .bbox_y_min_int(bbox_y_min_int), .bbox_y_max_int(bbox_y_max_int),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
        .done(done), .empty(empty), .pix_cnt(pix_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: enumerate rows top to bottom, each row left to right
    // (or right to left on odd row offsets in the serpentine build).
    task automatic build_expected(input int xmn, input int xmx, input int ymn, input int ymx);
        int xe, ye, x, w;
        bit rev, serp;
        exp_q.delete();
`ifdef RASTER_SERPENTINE_EN
        serp = 1'b1;
`else
        serp = 1'b0;
`endif
        exp_empty = (xmn > xmx) || (ymn > ymx) || (xmn >= IMG_W) || (ymn >= IMG_H);
        if (!exp_empty) begin
            xe = (xmx > IMG_W - 1) ? IMG_W - 1 : xmx;
            ye = (ymx > IMG_H - 1) ? IMG_H - 1 : ymx;
            w  = xe - xmn + 1;
            for (int y = ymn; y <= ye; y++) begin
                rev = serp && (((y - ymn) % 2) == 1);
                for (int k = 0; k < w; k++) begin
                    x = rev ? (xe - k) : (xmn + k);
                    exp_q.push_back({16'(x), 16'(y), (y == ye) && (k == w - 1)});
                end
            end
        end
    endtask

    function automatic int first_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // Drives one box and records what the DUT does; cycle 0 is the acceptance edge.
    // mode 0: ready always high, 1: random ready, 2: ready low 3 cycles while the second pixel shows.
    task automatic walk_box(input int xmn, input int xmx, input int ymn, input int ymx,
                            input int mode, input int max_cyc);
        int cyc, hs, stall_n;
        bit prev_stall;
        logic [32:0] prev_pix;
        obs_q.delete();
        r_done_cyc = -1; r_last_hs = -1; r_first_valid = -1; r_hold_bad = 0; r_done_pulses = 0;
        r_timeout = 1'b0; r_empty = 1'b0; r_ready_after = 1'b0; r_ready_at_done = 1'b1; r_cnt = '0;
        @(negedge clk);
        for (int i = 0; i < 50 && !bbox_ready; i++) @(negedge clk);
        bbox_x_min_int = 16'(xmn); bbox_x_max_int = 16'(xmx);
        bbox_y_min_int = 16'(ymn); bbox_y_max_int = 16'(ymx);
        bbox_valid = 1'b1;
        pix_ready  = 1'b0;
        @(posedge clk);
        cyc = 0; hs = 0; stall_n = 0; prev_stall = 1'b0; prev_pix = '0;
        while (1) begin
            @(negedge clk);
            cyc++;
            bbox_valid = 1'b0;
            if (prev_stall && ({pix_x, pix_y, pix_last} !== prev_pix)) r_hold_bad++;
            if (done) begin
                r_done_pulses++;
                r_done_cyc = cyc; r_empty = empty; r_cnt = pix_cnt; r_ready_at_done = bbox_ready;
                pix_ready = 1'b0;
                break;
            end
            if (pix_valid && r_first_valid < 0) r_first_valid = cyc;
            case (mode)
                0: pix_ready = 1'b1;
                1: pix_ready = ($urandom_range(0, 9) < 7);
                default: begin
                    if (hs == 1 && stall_n < 3) begin
                        pix_ready = 1'b0;
                        stall_n++;
                    end else begin
                        pix_ready = 1'b1;
                    end
                end
            endcase
            if (pix_valid && pix_ready) begin
                obs_q.push_back({pix_x, pix_y, pix_last});
                hs++;
                r_last_hs = cyc;
            end
            prev_stall = pix_valid && !pix_ready;
            prev_pix   = {pix_x, pix_y, pix_last};
            if (cyc >= max_cyc) begin
                r_timeout = 1'b1;
                pix_ready = 1'b0;
                break;
            end
        end
        @(negedge clk);
        r_ready_after = bbox_ready;
        if (done) r_done_pulses++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({bbox_ready, pix_valid, pix_x, pix_y, pix_last, done, empty, pix_cnt} !== RESET_VALS) begin
            bad++;
            $display("FAIL reset_values: got %h want %h",
                     {bbox_ready, pix_valid, pix_x, pix_y, pix_last, done, empty, pix_cnt}, RESET_VALS);
        end
        rst = 1'b0;
        $display("reset: outputs sampled");
    endtask

    task automatic test_basic();
        int d;
        build_expected(1, 2, 3, 4);
        walk_box(1, 2, 3, 4, 0, 100);
        d = first_diff();
        $display("basic box x1..2 y3..4: %0d pixels, done at cycle %0d", obs_q.size(), r_done_cyc);
        total++; if (r_timeout) begin bad++; $display("FAIL basic_timeout: got 1 want 0"); end
        total++; if (d != -1) begin bad++; $display("FAIL basic_stream: first diff at %0d, got %0d pixels want %0d", d, obs_q.size(), exp_q.size()); end
        total++; if (r_cnt !== 17'd4) begin bad++; $display("FAIL basic_cnt: got %0d want 4", r_cnt); end
        total++; if (r_empty !== 1'b0) begin bad++; $display("FAIL basic_empty: got %0d want 0", r_empty); end
        total++; if (r_first_valid != 1) begin bad++; $display("FAIL basic_first_latency: got %0d want 1", r_first_valid); end
        total++; if (r_done_cyc != 5) begin bad++; $display("FAIL basic_done_cycle: got %0d want 5", r_done_cyc); end
        total++; if (r_ready_at_done !== 1'b0 || r_ready_after !== 1'b1) begin bad++; $display("FAIL basic_ready_return: got %0d%0d want 01", r_ready_at_done, r_ready_after); end
        total++; if (r_done_pulses != 1) begin bad++; $display("FAIL basic_done_pulse: got %0d want 1", r_done_pulses); end
    endtask

    task automatic test_backpressure();
        int d;
        build_expected(1, 2, 3, 4);
        walk_box(1, 2, 3, 4, 2, 100);
        d = first_diff();
        $display("backpressure box x1..2 y3..4: %0d pixels, done at cycle %0d", obs_q.size(), r_done_cyc);
        total++; if (d != -1) begin bad++; $display("FAIL bp_stream: first diff at %0d, got %0d pixels want %0d", d, obs_q.size(), exp_q.size()); end
        total++; if (r_hold_bad != 0) begin bad++; $display("FAIL bp_hold: got %0d changes want 0", r_hold_bad); end
        total++; if (r_cnt !== 17'd4) begin bad++; $display("FAIL bp_cnt: got %0d want 4", r_cnt); end
        total++; if (r_done_cyc != 8 || r_done_cyc != r_last_hs + 1) begin bad++; $display("FAIL bp_done_cycle: got %0d want 8 (last hs %0d)", r_done_cyc, r_last_hs); end
    endtask

    task automatic test_empty();
        int boxes[4][4] = '{'{5, 4, 0, 0}, '{0, 3, 9, 8}, '{256, 300, 0, 0}, '{0, 0, 256, 260}};
        for (int i = 0; i < 4; i++) begin
            walk_box(boxes[i][0], boxes[i][1], boxes[i][2], boxes[i][3], 0, 20);
            $display("empty box %0d: done at cycle %0d empty=%0d cnt=%0d", i, r_done_cyc, r_empty, r_cnt);
            total++; if (obs_q.size() != 0 || r_first_valid != -1) begin bad++; $display("FAIL empty_%0d_pixels: got %0d pixels want 0", i, obs_q.size()); end
            total++; if (r_done_cyc != 1) begin bad++; $display("FAIL empty_%0d_done_cycle: got %0d want 1", i, r_done_cyc); end
            total++; if (r_empty !== 1'b1 || r_cnt !== 17'd0) begin bad++; $display("FAIL empty_%0d_flags: got empty=%0d cnt=%0d want 1 0", i, r_empty, r_cnt); end
        end
    endtask

    task automatic test_clip();
        int d;
        build_expected(254, 300, 1, 1);
        walk_box(254, 300, 1, 1, 0, 50);
        d = first_diff();
        $display("clip box x254..300 y1: %0d pixels", obs_q.size());
        total++; if (d != -1 || obs_q.size() != 2) begin bad++; $display("FAIL clip_stream: first diff at %0d, got %0d pixels want 2", d, obs_q.size()); end
        total++; if (r_cnt !== 17'd2) begin bad++; $display("FAIL clip_cnt: got %0d want 2", r_cnt); end
    endtask

    task automatic test_row_order();
        int d;
        build_expected(0, 2, 0, 1);
        walk_box(0, 2, 0, 1, 0, 50);
        d = first_diff();
        $display("row order box x0..2 y0..1: %0d pixels", obs_q.size());
        total++; if (d != -1) begin bad++; $display("FAIL order_stream: first diff at %0d, got %0d pixels want %0d", d, obs_q.size(), exp_q.size()); end
        total++; if (r_done_cyc != 7) begin bad++; $display("FAIL order_done_cycle: got %0d want 7", r_done_cyc); end
    endtask

    task automatic test_full_image();
        int d;
        build_expected(0, 255, 0, 255);
        walk_box(0, 255, 0, 255, 0, 70000);
        d = first_diff();
        $display("full image: %0d pixels, done at cycle %0d, cnt=%0d", obs_q.size(), r_done_cyc, r_cnt);
        total++; if (d != -1) begin bad++; $display("FAIL full_stream: first diff at %0d, got %0d pixels want %0d", d, obs_q.size(), exp_q.size()); end
        total++; if (r_cnt !== 17'd65536) begin bad++; $display("FAIL full_cnt: got %0d want 65536", r_cnt); end
        total++; if (obs_q.size() == 0 || obs_q[obs_q.size() - 1] !== {16'd255, 16'd255, 1'b1}) begin bad++; $display("FAIL full_last_pixel: got %0d pixels, final pixel not (255,255,last)", obs_q.size()); end
        total++; if (r_done_cyc != 65537) begin bad++; $display("FAIL full_done_cycle: got %0d want 65537", r_done_cyc); end
    endtask

    task automatic test_reset_midwalk();
        int hs, saw_done;
        @(negedge clk);
        for (int i = 0; i < 50 && !bbox_ready; i++) @(negedge clk);
        bbox_x_min_int = 16'd10; bbox_x_max_int = 16'd13;
        bbox_y_min_int = 16'd20; bbox_y_max_int = 16'd23;
        bbox_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bbox_valid = 1'b0;
        pix_ready  = 1'b1;
        hs = 0;
        for (int i = 0; i < 20 && hs < 5; i++) begin
            if (pix_valid) hs++;
            if (hs < 5) @(negedge clk);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bbox_ready, pix_valid, pix_x, pix_y, pix_last, done, empty, pix_cnt} !== RESET_VALS) begin
            bad++;
            $display("FAIL midwalk_reset_values: got %h want %h",
                     {bbox_ready, pix_valid, pix_x, pix_y, pix_last, done, empty, pix_cnt}, RESET_VALS);
        end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        pix_ready = 1'b0;
        total++; if (saw_done != 0) begin bad++; $display("FAIL midwalk_no_done: got %0d done pulses want 0", saw_done); end
        walk_box(7, 7, 7, 7, 0, 20);
        $display("after mid-walk reset: 1x1 box gave %0d pixels cnt=%0d", obs_q.size(), r_cnt);
        total++; if (obs_q.size() != 1 || obs_q[0] !== {16'd7, 16'd7, 1'b1}) begin bad++; $display("FAIL midwalk_single_pixel: got %0d pixels want 1 at (7,7,last)", obs_q.size()); end
        total++; if (r_cnt !== 17'd1 || r_done_cyc != 2) begin bad++; $display("FAIL midwalk_single_cnt: got cnt=%0d done at %0d want 1 at 2", r_cnt, r_done_cyc); end
    endtask

    task automatic test_random();
        int xmn, xmx, ymn, ymx, d;
        for (int n = 0; n < 30; n++) begin
            xmn = $urandom_range(0, 259);
            ymn = $urandom_range(0, 259);
            xmx = xmn + $urandom_range(0, 6);
            ymx = ymn + $urandom_range(0, 5);
            if ($urandom_range(0, 9) == 0 && xmn > 0) xmx = xmn - 1;
            if ($urandom_range(0, 9) == 0) xmx = 1000;
            build_expected(xmn, xmx, ymn, ymx);
            walk_box(xmn, xmx, ymn, ymx, 1, 2000);
            d = first_diff();
            $display("random box %0d: x %0d..%0d y %0d..%0d -> %0d pixels cnt=%0d empty=%0d",
                     n, xmn, xmx, ymn, ymx, obs_q.size(), r_cnt, r_empty);
            total++; if (r_timeout || d != -1) begin bad++; $display("FAIL rand_%0d_stream: timeout=%0d first diff %0d got %0d pixels want %0d", n, r_timeout, d, obs_q.size(), exp_q.size()); end
            total++; if (r_cnt !== 17'(exp_q.size()) || r_empty !== exp_empty) begin bad++; $display("FAIL rand_%0d_summary: got cnt=%0d empty=%0d want %0d %0d", n, r_cnt, r_empty, exp_q.size(), exp_empty); end
            total++; if (r_hold_bad != 0) begin bad++; $display("FAIL rand_%0d_hold: got %0d changes want 0", n, r_hold_bad); end
            total++; if (r_done_cyc != (exp_empty ? 1 : r_last_hs + 1)) begin bad++; $display("FAIL rand_%0d_done_cycle: got %0d last hs %0d", n, r_done_cyc, r_last_hs); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_clip();
        test_row_order();
        test_reset_midwalk();
        test_random();
        test_full_image();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
